// File: rtl/fifo_rx_pkg.sv
// Shared defaults, pointer/count types and APB response codes for the RX byte FIFO.
package fifo_rx_pkg;
    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned DEPTH_DEF  = 16;
    localparam int unsigned PTR_W_DEF  = $clog2(DEPTH_DEF);
    localparam int unsigned CNT_W_DEF  = $clog2(DEPTH_DEF + 1);

    typedef logic [PTR_W_DEF-1:0] ptr_t;
    typedef logic [CNT_W_DEF-1:0] count_t;

    localparam logic PSLVERR_OK  = 1'b0;
    localparam logic PSLVERR_ERR = 1'b1;
endpackage

// File: rtl/fifo_rx_apb_deser.sv
// LSB-first serial-to-parallel converter; byte_valid pulses on the edge that samples the last bit.
module rx_deser #(
    parameter int unsigned DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_cdr,
    input  logic              data_in,
    output logic [DATA_W-1:0] byte_data,
    output logic              byte_valid
);
    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

    // Holds the bits gathered so far, newest at the top, so the current bit completes the byte.
    logic [DATA_W-2:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;

    assign byte_data  = {data_in, shreg};
    assign byte_valid = en_cdr && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg   <= '0;
            bit_cnt <= '0;
        end else if (en_cdr) begin
            shreg   <= byte_data[DATA_W-1:1];
            bit_cnt <= byte_valid ? '0 : bit_cnt + CNT_W'(1);
        end
    end
endmodule

// File: rtl/fifo_rx_apb.sv
// RX byte FIFO: deserialised CDR bits stored in a circular buffer, drained by a read-only APB port.
module fifo_rx_apb
    import fifo_rx_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              en_cdr,
    input  logic              data_in,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    output logic [DATA_W-1:0] prdata,
    output logic              pready,
    output logic              pslverr,
    output logic              empty,
    output logic              full,
    output logic              overflow
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [CNT_W-1:0]  count_nxt;

    logic [DATA_W-1:0] byte_data;
    logic              byte_valid;
    logic              access;
    logic              pop;
    logic              push_ok;
    logic              drop;

    rx_deser #(.DATA_W(DATA_W)) u_deser (
        .clk        (clk),
        .reset      (reset),
        .en_cdr     (en_cdr),
        .data_in    (data_in),
        .byte_data  (byte_data),
        .byte_valid (byte_valid)
    );

    assign empty = (count == '0);
    assign full  = (count == CNT_FULL);

    // APB decode and push/pop arbitration; a pop on a full FIFO frees the slot for a same-edge push.
    always_comb begin
        access    = psel && penable;
        pready    = 1'b0;
        pslverr   = PSLVERR_OK;
        prdata    = '0;
        pop       = 1'b0;
        push_ok   = 1'b0;
        drop      = 1'b0;
        count_nxt = count;

        if (access) begin
            pready = 1'b1;
            if (pwrite || empty) begin
                pslverr = PSLVERR_ERR;
            end else begin
                prdata = mem[rd_ptr];
                pop    = 1'b1;
            end
        end

        if (byte_valid) begin
            if (!full || pop) push_ok = 1'b1;
            else              drop    = 1'b1;
        end

        if (push_ok && !pop)      count_nxt = count + CNT_W'(1);
        else if (pop && !push_ok) count_nxt = count - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count_nxt;
            if (drop) overflow <= 1'b1;
        end
    end

    // Storage carries no reset; occupancy alone decides which entries are meaningful.
    always_ff @(posedge clk) begin
        if (!reset && push_ok) mem[wr_ptr] <= byte_data;
    end
endmodule

// File: tb/tb_fifo_rx_apb.sv
// Directed bench for fifo_rx_apb: deserialiser, FIFO ordering, overflow, APB error paths and reset.
module tb_fifo_rx_apb;
    logic       clk = 1'b0;
    logic       reset;
    logic       en_cdr;
    logic       data_in;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] prdata;
    logic       pready;
    logic       pslverr;
    logic       empty;
    logic       full;
    logic       overflow;

    int checks = 0;
    int passed = 0;

    fifo_rx_apb dut (
        .clk      (clk),
        .reset    (reset),
        .en_cdr   (en_cdr),
        .data_in  (data_in),
        .psel     (psel),
        .penable  (penable),
        .pwrite   (pwrite),
        .prdata   (prdata),
        .pready   (pready),
        .pslverr  (pslverr),
        .empty    (empty),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic send_bit(input logic b);
        en_cdr  = 1'b1;
        data_in = b;
        tick();
        en_cdr  = 1'b0;
        data_in = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_bit(v[i]);
    endtask

    task automatic apb_read(input string tag, input logic [7:0] exp_data, input logic exp_err);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        #1;
        chk({tag, "_prdata"}, 32'(prdata), 32'(exp_data));
        chk({tag, "_pslverr"}, 32'(pslverr), 32'(exp_err));
        chk({tag, "_pready"}, 32'(pready), 32'd1);
        tick();
        psel = 1'b0; penable = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        for (int i = 0; i < cycles; i++) tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [7:0] a5;
        logic [7:0] v55;
        a5  = 8'hA5;
        v55 = 8'h55;
        en_cdr = 1'b0; data_in = 1'b0;
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        reset = 1'b0;
        tick();

        // Reset then idle
        do_reset(2);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);
        chk("rst_prdata", 32'(prdata), 32'd0);
        chk("rst_pready", 32'(pready), 32'd0);
        chk("rst_pslverr", 32'(pslverr), 32'd0);

        // Single byte A5, LSB first
        for (int i = 0; i < 7; i++) send_bit(a5[i]);
        chk("single_empty_7bits", 32'(empty), 32'd1);
        send_bit(a5[7]);
        chk("single_empty_8bits", 32'(empty), 32'd0);
        apb_read("single_rd", 8'hA5, 1'b0);
        chk("single_empty_after", 32'(empty), 32'd1);

        // Gapped strobe: data_in toggles while en_cdr is low and must be ignored
        for (int i = 0; i < 8; i++) begin
            send_bit(a5[i]);
            for (int g = 0; g < 3; g++) begin
                data_in = 1'(g & 1) ^ ~a5[i];
                tick();
            end
            data_in = 1'b0;
            if (i == 6) chk("gap_empty_7bits", 32'(empty), 32'd1);
        end
        apb_read("gap_rd", 8'hA5, 1'b0);
        chk("gap_empty_after", 32'(empty), 32'd1);

        // Fill to DEPTH, then one more byte is dropped
        for (int i = 0; i < 16; i++) begin
            send_byte(8'(i));
            if (i == 14) chk("fill_full_15", 32'(full), 32'd0);
        end
        chk("fill_full_16", 32'(full), 32'd1);
        chk("fill_ovf_16", 32'(overflow), 32'd0);
        send_byte(8'h10);
        chk("fill_full_17", 32'(full), 32'd1);
        chk("fill_ovf_17", 32'(overflow), 32'd1);
        for (int i = 0; i < 16; i++) apb_read($sformatf("drain_%0d", i), 8'(i), 1'b0);
        chk("drain_empty", 32'(empty), 32'd1);
        chk("drain_full", 32'(full), 32'd0);
        chk("drain_ovf_sticky", 32'(overflow), 32'd1);

        // Empty read is an error
        apb_read("empty_rd", 8'h00, 1'b1);
        chk("empty_rd_still_empty", 32'(empty), 32'd1);

        // Write access with one byte stored: error, no state change
        send_byte(8'h3C);
        psel = 1'b1; penable = 1'b1; pwrite = 1'b1;
        #1;
        chk("wr_pslverr", 32'(pslverr), 32'd1);
        chk("wr_prdata", 32'(prdata), 32'd0);
        chk("wr_pready", 32'(pready), 32'd1);
        tick();
        psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
        chk("wr_not_empty", 32'(empty), 32'd0);
        apb_read("wr_then_rd", 8'h3C, 1'b0);
        chk("wr_count_was_1", 32'(empty), 32'd1);

        // Full with push and pop on the same edge
        do_reset(1);
        chk("rst2_ovf", 32'(overflow), 32'd0);
        for (int i = 0; i < 16; i++) send_byte(8'(8'h20 + i));
        chk("sim_full", 32'(full), 32'd1);
        for (int i = 0; i < 7; i++) send_bit(v55[i]);
        en_cdr = 1'b1; data_in = v55[7];
        psel = 1'b1; penable = 1'b1; pwrite = 1'b0;
        #1;
        chk("sim_prdata", 32'(prdata), 32'h20);
        chk("sim_pslverr", 32'(pslverr), 32'd0);
        tick();
        en_cdr = 1'b0; data_in = 1'b0; psel = 1'b0; penable = 1'b0;
        chk("sim_full_after", 32'(full), 32'd1);
        chk("sim_ovf_after", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) apb_read($sformatf("sim_drain_%0d", i), 8'(8'h20 + i), 1'b0);
        apb_read("sim_last", 8'h55, 1'b0);
        chk("sim_empty", 32'(empty), 32'd1);

        // Reset mid-byte discards the partial byte
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_reset(1);
        chk("mid_rst_empty", 32'(empty), 32'd1);
        send_byte(8'h96);
        chk("mid_rst_not_empty", 32'(empty), 32'd0);
        apb_read("mid_rst_rd", 8'h96, 1'b0);
        chk("mid_rst_empty_after", 32'(empty), 32'd1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
